// File: rtl/pulse_util_pkg.sv
// rtl/pulse_util_pkg.sv - shared FSM states and debounce/stretch cycle calculation
package pulse_util_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        QUAL_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        QUAL_LOW  = 2'd3
    } pulse_state_e;

    // Never returns less than one cycle so a zero debounce time still registers the level.
    function automatic int stable_cycles(input int clk_hz, input int debounce_us);
        int c;
        c = $rtoi(real'(clk_hz) / 1.0e6 * real'(debounce_us));
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for one asynchronous bit
module bit_synchronizer #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {N{INIT}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pulse_debouncer.sv
// rtl/pulse_debouncer.sv - debounced level with rise/fall strobes
// Optional high-time measurement enabled by PULSE_WIDTH_MEASURE_EN.
module pulse_debouncer
    import pulse_util_pkg::*;
#(
    parameter int   CLK_FREQUENCY = 100000000,
    parameter int   DEBOUNCE_US   = 1000,
    parameter int   SYNC_STAGES   = 2,
    parameter logic INITIAL_LEVEL = 1'b0,
    parameter int   WIDTH_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pulseIn,
    output logic                  level,
    output logic                  riseStrobe,
    output logic                  fallStrobe,
    output logic [WIDTH_BITS-1:0] widthCount,
    output logic                  widthValid
);

    localparam int STABLE_CYCLES = stable_cycles(CLK_FREQUENCY, DEBOUNCE_US);
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic SKIP_QUAL   = (STABLE_CYCLES == 1);

    pulse_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             sync_s;
    logic             rise_evt;
    logic             fall_evt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES),
        .INIT   (INITIAL_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pulseIn),
        .q_o (sync_s)
    );

    // Qualification completes on the edge that sees the last required stable sample.
    assign rise_evt = sync_s &&
                      ((state_q == QUAL_HIGH && cnt_q == LAST_CNT) ||
                       (state_q == IDLE_LOW && SKIP_QUAL));
    assign fall_evt = !sync_s &&
                      ((state_q == QUAL_LOW && cnt_q == LAST_CNT) ||
                       (state_q == IDLE_HIGH && SKIP_QUAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INITIAL_LEVEL ? IDLE_HIGH : IDLE_LOW;
            cnt_q   <= '0;
            level_q <= INITIAL_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (rise_evt) begin
                state_q <= IDLE_HIGH;
                cnt_q   <= '0;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
            end else if (fall_evt) begin
                state_q <= IDLE_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE_LOW: if (sync_s) begin
                        state_q <= QUAL_HIGH;
                        cnt_q   <= CNT_W'(1);
                    end
                    QUAL_HIGH: if (!sync_s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    IDLE_HIGH: if (!sync_s) begin
                        state_q <= QUAL_LOW;
                        cnt_q   <= CNT_W'(1);
                    end
                    QUAL_LOW: if (sync_s) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    default: begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign level      = level_q;
    assign riseStrobe = rise_q;
    assign fallStrobe = fall_q;

`ifdef PULSE_WIDTH_MEASURE_EN
    logic [WIDTH_BITS-1:0] hi_cnt_q;
    logic [WIDTH_BITS-1:0] hi_cnt_inc;
    logic [WIDTH_BITS-1:0] width_q;
    logic                  width_valid_q;

    assign hi_cnt_inc = (&hi_cnt_q) ? hi_cnt_q : hi_cnt_q + WIDTH_BITS'(1);

    // The riseStrobe cycle is the first high cycle; the fall edge adds the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_q      <= '0;
            width_q       <= '0;
            width_valid_q <= 1'b0;
        end else begin
            width_valid_q <= 1'b0;
            if (level_q) begin
                hi_cnt_q <= rise_q ? WIDTH_BITS'(1) : hi_cnt_inc;
            end
            if (fall_evt) begin
                width_q       <= rise_q ? WIDTH_BITS'(1) : hi_cnt_inc;
                width_valid_q <= 1'b1;
            end
        end
    end

    assign widthCount = width_q;
    assign widthValid = width_valid_q;
`else
    assign widthCount = '0;
    assign widthValid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_debouncer.sv
// tb/tb_pulse_debouncer.sv - scoreboard bench for pulse_debouncer
module tb_pulse_debouncer;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulseIn;
    logic        level;
    logic        riseStrobe;
    logic        fallStrobe;
    logic [31:0] widthCount;
    logic        widthValid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    typedef struct {
        logic rise;
        int   cyc;
        int   width;
    } exp_t;

    exp_t sb_q[$];

    pulse_debouncer #(
        .CLK_FREQUENCY (1000000),
        .DEBOUNCE_US   (4),
        .SYNC_STAGES   (2),
        .INITIAL_LEVEL (1'b0),
        .WIDTH_BITS    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulseIn    (pulseIn),
        .level      (level),
        .riseStrobe (riseStrobe),
        .fallStrobe (fallStrobe),
        .widthCount (widthCount),
        .widthValid (widthValid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        pulseIn = v;
        tick(n);
    endtask

    task automatic push_exp(input logic r, input int w);
        sb_q.push_back(exp_t'{rise: r, cyc: cyc + LAT, width: w});
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_rise"}, 32'(riseStrobe), 0);
        check({tag, "_fall"}, 32'(fallStrobe), 0);
        check({tag, "_wvalid"}, 32'(widthValid), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        check("both_strobes", 32'(riseStrobe & fallStrobe), 0);
        check("wvalid_alone", 32'(widthValid & ~fallStrobe), 0);
        if (riseStrobe || fallStrobe) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'({riseStrobe, fallStrobe}), 0);
            end else begin
                e = sb_q.pop_front();
                check("strobe_kind", 32'(riseStrobe), 32'(e.rise));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("level_at_strobe", 32'(level), 32'(e.rise));
                if (!e.rise) begin
`ifdef PULSE_WIDTH_MEASURE_EN
                    check("width_valid", 32'(widthValid), 1);
                    check("width_count", widthCount, 32'(e.width));
`else
                    check("width_valid", 32'(widthValid), 0);
                    check("width_count", widthCount, 0);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        pulseIn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_quiet("reset");
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        pulseIn = 1'b0;
        tick(8);
        check("idle_level", 32'(level), 0);

        // clean rise, then a 3-cycle low glitch while high, then a clean fall
        push_exp(1'b1, 0);
        drive(1'b1, 12);
        check("rise_level", 32'(level), 1);
        drive(1'b0, 3);
        drive(1'b1, 8);
        check("low_glitch_level", 32'(level), 1);
        push_exp(1'b0, 23);
        drive(1'b0, 10);
        check("fall_level", 32'(level), 0);

        // short high glitch is rejected
        drive(1'b1, 3);
        drive(1'b0, 10);
        check("glitch_level", 32'(level), 0);

        // bounce: only the final edge qualifies
        drive(1'b1, 2);
        drive(1'b0, 1);
        push_exp(1'b1, 0);
        drive(1'b1, 10);
        check("bounce_level", 32'(level), 1);
        push_exp(1'b0, 10);
        drive(1'b0, 10);
        check("bounce_fall_level", 32'(level), 0);

        // reset during qualification aborts it; qualification restarts on release
        drive(1'b1, 4);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_quiet("mid_reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0  = cyc;
        push_exp(1'b1, 0);
        tick(12);
        check("post_reset_level", 32'(level), 1);
        push_exp(1'b0, cyc - t0);
        drive(1'b0, 10);

        // clean 20-cycle high for width measurement
        push_exp(1'b1, 0);
        drive(1'b1, 20);
        push_exp(1'b0, 20);
        drive(1'b0, 12);
        check("final_level", 32'(level), 0);

        check("sb_pending", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
